lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_LATENCY_MAX, default 16, meaning the cycle limit for waiting on read data before flagging a timeout error.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have core-side request ports:
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  zero-extend load when 1
- req_wdata  in  32  store data, right-aligned
REQ-005 SHALL have core-side response ports:
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data
- rsp_err  out  1  misaligned, illegal size or timeout
REQ-006 SHALL have memory-side ports:
- mem_valid  out  1
- mem_ready  in  1
- mem_we  out  1
- mem_addr  out  32  word-aligned, bits[1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32
- mem_rvalid  in  1
- mem_rdata  in  32

Function
REQ-007 SHALL implement FSM states IDLE, MEM_REQ, MEM_WAIT, RESP; all outputs registered.
REQ-008 IDLE SHALL drive req_ready=1; all other states SHALL drive req_ready=0.
REQ-009 On acceptance (req_valid & req_ready), SHALL capture addr, size, we, unsigned and wdata.
REQ-010 Misalignment SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-011 A misaligned request SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL issue no memory access.
REQ-012 Otherwise SHALL go to MEM_REQ with mem_valid=1 and mem_addr={addr[31:2],2'b00}.
REQ-013 MEM_REQ SHALL hold mem_valid and all mem_* outputs stable until mem_ready=1.
REQ-014 mem_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, 4'b1111 for word; mem_be SHALL be driven for loads too.
REQ-015 Store mem_wdata SHALL replicate the byte to all four lanes, the half to both halves, or pass the word unchanged.
REQ-016 On mem_ready: a store SHALL go to RESP; a load SHALL go to MEM_WAIT; mem_valid SHALL drop the next cycle.
REQ-017 MEM_WAIT SHALL accept mem_rvalid, including in the first cycle, then go to RESP.
REQ-018 Load data SHALL extract the addressed lane and sign-extend it, or zero-extend it when req_unsigned=1.
REQ-019 If MEM_LATENCY_MAX cycles pass in MEM_WAIT without mem_rvalid, SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-021 Store responses SHALL have rsp_rdata=0.
REQ-022 rsp_err and rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-023 mem_rvalid outside MEM_WAIT SHALL be ignored.
REQ-024 Latency with zero memory wait SHALL be: accept at cycle N -> mem_valid at N+1; store rsp_valid at N+2; load rsp_valid at N+3 when mem_rvalid arrives at N+2; misaligned rsp_valid at N+1.

Reset
REQ-025 While rst_n=0, SHALL drive state=IDLE and all outputs 0, except req_ready=0.
REQ-026 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-027 Reset asserted mid-transaction SHALL immediately deassert mem_valid and rsp_valid, with no response generated afterwards.

Verification
REQ-028 SHALL cover a store byte: addr=0x1003, wdata=0x000000A5 -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, rsp_valid at N+2, rsp_rdata=0.
REQ-029 SHALL cover a load half, signed: addr=0x2002, mem_rdata=0x8001_1234 -> mem_be=1100, rsp_rdata=0xFFFF8001; with req_unsigned=1 -> 0x00008001.
REQ-030 SHALL cover a misaligned word load at addr=0x3001 -> no mem_valid, rsp_valid at N+1, rsp_err=1, rsp_rdata=0.
REQ-031 SHALL cover backpressure: mem_ready low for 3 cycles -> mem_* stable throughout, req_ready=0, response follows the mem_ready cycle.
REQ-032 SHALL cover read timeout: mem_rvalid never returned -> rsp_err=1 after MEM_LATENCY_MAX=16 cycles in MEM_WAIT.
REQ-033 SHALL cover reset mid-transaction: rst_n low during MEM_WAIT -> mem_valid=0 and no rsp_valid; a late mem_rvalid is ignored; req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with alignment
// checks, byte-lane steering and a bounded read wait.
module lsu #(
  parameter int MEM_LATENCY_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE, MEM_REQ, MEM_WAIT, RESP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic          we_q, uns_q;
  logic          accept;

  logic          req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          mem_valid_d, mem_we_d;
  logic [31:0]   mem_addr_d, mem_wdata_d;
  logic [3:0]    mem_be_d;

  function automatic logic misaligned(
    input logic [1:0] a,
    input logic [1:0] sz
  );
    logic m;
    unique case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [1:0] a,
    input logic [1:0] sz
  );
    logic [3:0] be;
    unique case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] fmt_wdata(
    input logic [31:0] d,
    input logic [1:0]  sz
  );
    logic [31:0] w;
    unique case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ext_rdata(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [31:0] lane;
    logic [31:0] r;
    lane = d >> {a, 3'b000};
    unique case (sz)
      2'b00:   r = {{24{~uns & lane[7]}}, lane[7:0]};
      2'b01:   r = {{16{~uns & lane[15]}}, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  assign accept = req_valid & req_ready;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_valid_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    unique case (state)
      IDLE: begin
        if (!accept) begin
          req_ready_d = 1'b1;
        end else if (misaligned(req_addr[1:0], req_size)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d     = MEM_REQ;
          mem_valid_d = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = lane_be(req_addr[1:0], req_size);
          if (req_we)
            mem_wdata_d = fmt_wdata(req_wdata, req_size);
        end
      end
      MEM_REQ: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = '0;
          end
        end else begin
          // Rebuild from the captured request so the bus holds steady.
          mem_valid_d = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = {addr_q[31:2], 2'b00};
          mem_be_d    = lane_be(addr_q[1:0], size_q);
          if (we_q)
            mem_wdata_d = fmt_wdata(wdata_q, size_q);
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ext_rdata(mem_rdata, addr_q[1:0],
                                  size_q, uns_q);
        end else if (cnt == CW'(MEM_LATENCY_MAX - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_valid <= mem_valid_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
      end
    end
  end

endmodule
